// File: rtl/uart_ram_programmer.sv
// UART-driven program loader. Watches an 8N1 RX line for a magic byte
// sequence, then holds the system in reset and streams little-endian 32-bit
// words to consecutive RAM word addresses until the line goes idle.
module uart_ram_programmer #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned SEQ_LENGTH   = 4,
    parameter logic [8*SEQ_LENGTH-1:0] MAGIC_SEQ = "PROG",
    parameter int unsigned BREAK_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    output logic [31:0] prog_addr_o,
    output logic [31:0] prog_data_o,
    output logic        prog_valid_o,
    output logic        prog_mode_o,
    output logic        system_reset_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned TMR_W        = $clog2(BREAK_CYCLES) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BREAK_CYCLES - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic {
        ST_IDLE,
        ST_PROG
    } state_e;

    // ------------------------------------------------------------------
    // RX receiver
    // ------------------------------------------------------------------
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       rx_shift_q;
    logic             bit_tick;
    logic             byte_valid;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    // NOTE: clocked blocks use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_state_q <= RX_IDLE;
        else         rx_state_q <= rx_state_d;
    end

    // RX next-state: start re-checked at mid-bit, then one sample per bit period.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rx_state_d = rx_state_q;
        byte_valid = 1'b0;
        bit_tick   = (rx_state_q == RX_START) ? (clk_cnt_q == HALF_LAST)
                                              : (clk_cnt_q == BIT_LAST);
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (bit_tick) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (bit_tick && bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (bit_tick) begin
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX datapath: bit timer, bit index and LSB-first shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            rx_shift_q <= '0;
        end else begin
            if (rx_state_q == RX_IDLE || rx_state_d != rx_state_q || bit_tick)
                clk_cnt_q <= '0;
            else
                clk_cnt_q <= clk_cnt_q + 1'b1;

            if (rx_state_q == RX_START) begin
                bit_idx_q <= '0;
            end else if (rx_state_q == RX_DATA && bit_tick) begin
                rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                bit_idx_q  <= bit_idx_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [8*SEQ_LENGTH-1:0] magic_q, magic_shift;
    logic [31:0]             addr_cnt_q;
    logic [1:0]              idx_q;
    logic [23:0]             word_q;
    logic [TMR_W-1:0]        timer_q;

    // Candidate shift-register value with the received byte entering as LSB.
    always_comb begin
        magic_shift      = magic_q << 8;
        magic_shift[7:0] = rx_shift_q;
    end

    // Loader state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Loader next-state: magic match enters PROG, idle timeout leaves it
    // unless a byte completes in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (magic_q == MAGIC_SEQ)               state_d = ST_PROG;
            ST_PROG: if (!byte_valid && timer_q == TMR_LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Loader datapath: magic shifting, word assembly, write strobe, idle timer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            magic_q        <= '0;
            addr_cnt_q     <= '0;
            idx_q          <= '0;
            word_q         <= '0;
            timer_q        <= '0;
            prog_addr_o    <= '0;
            prog_data_o    <= '0;
            prog_valid_o   <= 1'b0;
            prog_mode_o    <= 1'b0;
            system_reset_o <= 1'b0;
        end else begin
            prog_valid_o   <= 1'b0;
            prog_mode_o    <= (state_d == ST_PROG);
            system_reset_o <= (state_d == ST_PROG);

            if (state_q == ST_IDLE) begin
                timer_q <= '0;
                if (state_d == ST_PROG) begin
                    magic_q    <= '0;
                    addr_cnt_q <= '0;
                    idx_q      <= '0;
                    word_q     <= '0;
                end else if (byte_valid) begin
                    magic_q <= magic_shift;
                end
            end else if (byte_valid) begin
                timer_q <= '0;
                if (idx_q == 2'd3) begin
                    prog_data_o  <= {rx_shift_q, word_q};
                    prog_addr_o  <= addr_cnt_q;
                    prog_valid_o <= 1'b1;
                    addr_cnt_q   <= addr_cnt_q + 1'b1;
                    idx_q        <= '0;
                end else begin
                    word_q[8*idx_q +: 8] <= rx_shift_q;
                    idx_q                <= idx_q + 1'b1;
                end
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_ram_programmer.sv
// Self-checking bench for uart_ram_programmer: directed UART frames drive the
// loader; expected RAM writes are queued and checked by an independent monitor.
module tb_uart_ram_programmer;

    localparam int CPB   = 10;   // 1 MHz / 100 kbaud
    localparam int GAP   = 20;   // idle clocks after each frame
    localparam int BREAK = 2000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] prog_addr_o, prog_data_o;
    logic        prog_valid_o, prog_mode_o, system_reset_o;

    int n_compared = 0;
    int n_mismatch = 0;
    logic [63:0] exp_q[$];

    uart_ram_programmer #(
        .CLK_FREQ    (1_000_000),
        .BAUD_RATE   (100_000),
        .SEQ_LENGTH  (4),
        .MAGIC_SEQ   ("PROG"),
        .BREAK_CYCLES(BREAK)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .uart_rx_i     (uart_rx),
        .prog_addr_o   (prog_addr_o),
        .prog_data_o   (prog_data_o),
        .prog_valid_o  (prog_valid_o),
        .prog_mode_o   (prog_mode_o),
        .system_reset_o(system_reset_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the head of the queue.
    always @(negedge clk_i) begin
        if (rst_ni && prog_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {prog_addr_o, prog_data_o}, 64'hx);
            end else begin
                check("write", {prog_addr_o, prog_data_o}, exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk_i);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk_i);
        uart_rx = 1'b1;
        repeat (GAP) @(negedge clk_i);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic check_mode(input string name, input logic exp);
        check({name, "_mode"}, prog_mode_o, exp);
        check({name, "_sysrst"}, system_reset_o, exp);
    endtask

    task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_addr", prog_addr_o, 0);
        check("rst_data", prog_data_o, 0);
        check("rst_valid", prog_valid_o, 0);
        check_mode("rst", 1'b0);
        rst_ni = 1'b1;
        repeat (30) @(negedge clk_i);

        // 1: magic then two words
        send_str("PRO");
        check_mode("t1_pre_g", 1'b0);
        send_str("G");
        check_mode("t1_after_g", 1'b1);
        push_write(32'd0, 32'h1234_5678);
        push_write(32'd1, 32'hDEAD_BEEF);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);

        // 2: idle timeout
        repeat (BREAK - 100) @(negedge clk_i);
        check_mode("t2_before_timeout", 1'b1);
        repeat (200) @(negedge clk_i);
        check_mode("t2_after_timeout", 1'b0);
        check("t2_sb_empty", exp_q.size(), 0);

        // 3: magic after junk prefixes, then a near-miss
        send_str("XPROG");
        check_mode("t3_xprog", 1'b1);
        repeat (BREAK + 100) @(negedge clk_i);
        check_mode("t3_xprog_exit", 1'b0);
        send_str("PRPROG");
        check_mode("t3_prprog", 1'b1);
        repeat (BREAK + 100) @(negedge clk_i);
        check_mode("t3_prprog_exit", 1'b0);
        send_str("PROX");
        repeat (50) @(negedge clk_i);
        check_mode("t3_prox", 1'b0);

        // 4: partial word discarded on timeout, fresh start at addr 0
        send_str("PROG");
        check_mode("t4_enter", 1'b1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        repeat (BREAK + 100) @(negedge clk_i);
        check_mode("t4_partial_exit", 1'b0);
        send_str("PROG");
        push_write(32'd0, 32'h0403_0201);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        repeat (BREAK + 100) @(negedge clk_i);
        check_mode("t4_exit", 1'b0);

        // 5: framing error and start glitch must not reach the shift register
        send_str("PRO");
        send_byte("G", 1'b0);
        check_mode("t5_bad_stop", 1'b0);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk_i);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk_i);
        check_mode("t5_glitch", 1'b0);
        send_str("G");
        check_mode("t5_clean_g", 1'b1);

        // 6: reset mid-word mid-frame
        send_byte(8'h55); send_byte(8'h66);
        uart_rx = 1'b0;
        repeat (25) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_addr", prog_addr_o, 0);
        check("t6_rst_valid", prog_valid_o, 0);
        check_mode("t6_rst", 1'b0);
        uart_rx = 1'b1;
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (30) @(negedge clk_i);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check_mode("t6_no_magic", 1'b0);
        send_str("PROG");
        check_mode("t6_reenter", 1'b1);
        push_write(32'd0, 32'h4433_2211);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("t6_hold_addr", prog_addr_o, 32'd0);
        check("t6_hold_data", prog_data_o, 32'h4433_2211);
        check("t6_hold_valid", prog_valid_o, 0);
        repeat (BREAK + 100) @(negedge clk_i);
        check_mode("t6_exit", 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
